// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-access scheduler: FSM states,
// requester identity, bank geometry and the port-B index check.
package regbank_pkg;

    localparam int DATA_W   = 16;
    localparam int SELA_W   = 5;
    localparam int SELB_W   = 6;
    localparam int REG_MAX  = 27;
    localparam int WREG_IDX = 34;
    localparam int TMO_CYC  = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        CAP  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        ERR  = 3'd5
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    // Port B reaches the general registers plus the working register.
    function automatic logic idx_valid_b(input logic [SELB_W-1:0] idx);
        return (idx <= SELB_W'(REG_MAX)) || (idx == SELB_W'(WREG_IDX));
    endfunction

    function automatic logic idx_valid_a(input logic [SELA_W-1:0] idx);
        return idx <= SELA_W'(REG_MAX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (core vs debug); arbitrates only while
// enabled and remembers the last winner so a tie goes to the other side.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req_core,
    input  logic i_req_dbg,
    output logic o_gnt_core,
    output logic o_gnt_dbg
);

    logic r_last_dbg;

    always_comb begin
        o_gnt_core = 1'b0;
        o_gnt_dbg  = 1'b0;
        if (i_en) begin
            if (i_req_core && i_req_dbg) begin
                o_gnt_core = r_last_dbg;
                o_gnt_dbg  = !r_last_dbg;
            end else begin
                o_gnt_core = i_req_core;
                o_gnt_dbg  = i_req_dbg;
            end
        end
    end

    // Starts as "debug won last" so the core takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dbg <= 1'b1;
        end else if (o_gnt_core) begin
            r_last_dbg <= 1'b0;
        end else if (o_gnt_dbg) begin
            r_last_dbg <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_access_sched.sv
// Sequences select -> capture -> ALU -> write-back for core requests and
// debug reads over the shared bank read mux. Option macro: ALU_TIMEOUT_EN.
module reg_access_sched
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic [SELA_W-1:0] core_sel_a,
    input  logic [SELB_W-1:0] core_sel_b,
    input  logic [SELB_W-1:0] core_dst,
    input  logic              core_we,
    output logic              core_done,
    output logic              core_err,
    input  logic              dbg_req,
    input  logic [SELB_W-1:0] dbg_sel,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic [SELA_W-1:0] sel_a,
    output logic [SELB_W-1:0] sel_b,
    output logic              update_block,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wr_en,
    output logic [SELB_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    state_t              r_state;
    state_t              w_state_next;
    owner_t              r_owner;
    logic [SELA_W-1:0]   r_sel_a;
    logic [SELB_W-1:0]   r_sel_b;
    logic [SELB_W-1:0]   r_dst;
    logic                r_we;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_dbg_data;
    logic                r_alu_start;
    logic                w_idle;
    logic                w_gnt_core;
    logic                w_gnt_dbg;
    logic                w_core_idx_ok;
    logic                w_dbg_idx_ok;
    logic                w_exec_tmo;

    assign w_idle = (r_state == IDLE);

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_idle),
        .i_req_core (core_req),
        .i_req_dbg  (dbg_req),
        .o_gnt_core (w_gnt_core),
        .o_gnt_dbg  (w_gnt_dbg)
    );

    assign w_core_idx_ok = idx_valid_a(core_sel_a) && idx_valid_b(core_sel_b)
                           && idx_valid_b(core_dst);
    assign w_dbg_idx_ok  = idx_valid_b(dbg_sel);

`ifdef ALU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts completed EXEC cycles; zero on the first EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset || (r_state != EXEC)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_exec_tmo = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
    assign w_exec_tmo = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_core) begin
                    w_state_next = w_core_idx_ok ? SEL : ERR;
                end else if (w_gnt_dbg) begin
                    w_state_next = w_dbg_idx_ok ? SEL : ERR;
                end
            end
            SEL:  w_state_next = CAP;
            // Debug reads skip the ALU; WB is then their response cycle.
            CAP:  w_state_next = (r_owner == OWN_DBG) ? WB : EXEC;
            EXEC: begin
                if (alu_done) begin
                    w_state_next = WB;
                end else if (w_exec_tmo) begin
                    w_state_next = ERR;
                end
            end
            WB:      w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CORE;
            r_sel_a     <= '0;
            r_sel_b     <= '0;
            r_dst       <= '0;
            r_we        <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_dbg_data  <= '0;
            r_alu_start <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_alu_start <= (r_state == CAP) && (r_owner == OWN_CORE);
            case (r_state)
                IDLE: begin
                    // Everything the transaction needs is latched at grant.
                    if (w_gnt_core) begin
                        r_owner <= OWN_CORE;
                        r_dst   <= core_dst;
                        r_we    <= core_we;
                        if (w_core_idx_ok) begin
                            r_sel_a <= core_sel_a;
                            r_sel_b <= core_sel_b;
                        end
                    end else if (w_gnt_dbg) begin
                        r_owner    <= OWN_DBG;
                        r_dbg_data <= '0;
                        if (w_dbg_idx_ok) begin
                            r_sel_b <= dbg_sel;
                        end
                    end
                end
                CAP: begin
                    if (r_owner == OWN_DBG) begin
                        r_dbg_data <= data_b;
                    end else begin
                        r_op_a <= data_a;
                        r_op_b <= data_b;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sel_a        = r_sel_a;
    assign sel_b        = r_sel_b;
    assign update_block = (r_state == SEL);
    assign alu_start    = r_alu_start;
    assign alu_op_a     = r_op_a;
    assign alu_op_b     = r_op_b;
    assign core_done    = ((r_state == WB) || (r_state == ERR)) && (r_owner == OWN_CORE);
    assign core_err     = (r_state == ERR) && (r_owner == OWN_CORE);
    assign dbg_valid    = ((r_state == WB) || (r_state == ERR)) && (r_owner == OWN_DBG);
    assign dbg_data     = r_dbg_data;
    assign wr_en        = (r_state == WB) && (r_owner == OWN_CORE) && r_we;
    assign wr_addr      = r_dst;
    assign wr_data      = r_result;

endmodule

// File: tb/tb_reg_access_sched.sv
// Scoreboard bench for reg_access_sched: bank/mux and ALU environment models,
// a spec-level reference model filling expectation queues, and a monitor.
module tb_reg_access_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0;
    logic [4:0]  core_sel_a = '0;
    logic [5:0]  core_sel_b = '0;
    logic [5:0]  core_dst = '0;
    logic        core_we = 1'b0;
    logic        core_done;
    logic        core_err;
    logic        dbg_req = 1'b0;
    logic [5:0]  dbg_sel = '0;
    logic        dbg_valid;
    logic [15:0] dbg_data;
    logic [4:0]  sel_a;
    logic [5:0]  sel_b;
    logic        update_block;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        alu_start;
    logic [15:0] alu_op_a;
    logic [15:0] alu_op_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_access_sched dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_sel_a   (core_sel_a),
        .core_sel_b   (core_sel_b),
        .core_dst     (core_dst),
        .core_we      (core_we),
        .core_done    (core_done),
        .core_err     (core_err),
        .dbg_req      (dbg_req),
        .dbg_sel      (dbg_sel),
        .dbg_valid    (dbg_valid),
        .dbg_data     (dbg_data),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .update_block (update_block),
        .data_a       (data_a),
        .data_b       (data_b),
        .alu_start    (alu_start),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    // ---------------- environment: register bank + combinational read mux
    logic [15:0] bank [0:34];
    logic        poke_en = 1'b0;
    int          poke_idx = 0;
    logic [15:0] poke_val = '0;

    always @(posedge clk) begin
        if (poke_en) bank[poke_idx] <= poke_val;
        else if (wr_en && (wr_addr <= 6'd34)) bank[wr_addr] <= wr_data;
    end

    always_comb begin
        data_a = 16'h0;
        if (sel_a <= 5'd27) data_a = bank[sel_a];
    end

    always_comb begin
        data_b = 16'h0;
        if ((sel_b <= 6'd27) || (sel_b == 6'd34)) data_b = bank[sel_b];
    end

    // ---------------- environment: adder ALU with programmable latency
    int          alu_dly = 0;
    bit          alu_hang = 1'b0;
    bit          alu_pend = 1'b0;
    int          alu_wait = 0;
    logic [15:0] alu_q = '0;
    int          inject_req = 0;
    int          inject_ack = 0;

    initial forever begin
        @(posedge clk); #1;
        alu_done = 1'b0;
        if (inject_req != inject_ack) begin
            inject_ack = inject_ack + 1;
            alu_done   = 1'b1;
            alu_result = 16'hDEAD;
        end
        if (alu_pend) begin
            if (alu_wait == 0) begin
                alu_done = 1'b1; alu_result = alu_q; alu_pend = 1'b0;
            end else begin
                alu_wait = alu_wait - 1;
            end
        end
        if (alu_start && !alu_hang) begin
            alu_q = alu_op_a + alu_op_b;
            if (alu_dly == 0) begin
                alu_done = 1'b1; alu_result = alu_q;
            end else begin
                alu_pend = 1'b1; alu_wait = alu_dly - 1;
            end
        end
    end

    // ---------------- reference model and expectation queues
    logic [15:0] mdl [0:34];
    bit          mdl_last_dbg = 1'b1;
    int          q_upd_a[$];
    int          q_upd_b[$];
    logic [15:0] q_op_a[$];
    logic [15:0] q_op_b[$];
    bit          q_err[$];
    int          q_wr_addr[$];
    logic [15:0] q_wr_data[$];
    logic [15:0] q_dbg[$];

    task automatic check(string name, longint act, longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic unexp(string name);
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s pulse with nothing expected t=%0t", name, $time);
    endtask

    task automatic timeout(string name);
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s timeout waiting for DUT t=%0t", name, $time);
    endtask

    function automatic bit ok_b(int i);
        return ((i >= 0) && (i <= 27)) || (i == 34);
    endfunction

    function automatic int core_lat(int a, int b, int d, int dly, bit hang);
        if ((a > 27) || !ok_b(b) || !ok_b(d)) return 1;
        if (hang) return 3 + 15;
        return 4 + dly;
    endfunction

    task automatic plan_core(int a, int b, int d, bit we, bit hang);
        logic [15:0] res;
        if ((a > 27) || !ok_b(b) || !ok_b(d)) begin
            q_err.push_back(1'b1);
        end else begin
            q_upd_a.push_back(a); q_upd_b.push_back(b);
            q_op_a.push_back(mdl[a]); q_op_b.push_back(mdl[b]);
            if (hang) begin
                q_err.push_back(1'b1);
            end else begin
                res = mdl[a] + mdl[b];
                q_err.push_back(1'b0);
                if (we) begin
                    q_wr_addr.push_back(d); q_wr_data.push_back(res);
                    mdl[d] = res;
                end
            end
        end
    endtask

    task automatic plan_dbg(int s);
        if (ok_b(s)) begin
            q_upd_a.push_back(-1); q_upd_b.push_back(s);
            q_dbg.push_back(mdl[s]);
        end else begin
            q_dbg.push_back(16'h0);
        end
    endtask

    // ---------------- monitor
    bit prev_upd = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_upd = 1'b0;
        end else begin
            if (update_block) begin
                check("upd_one_cycle", prev_upd, 0);
                if (q_upd_b.size() == 0) unexp("update_block");
                else begin
                    int ea, eb;
                    ea = q_upd_a.pop_front(); eb = q_upd_b.pop_front();
                    check("sel_b", sel_b, eb);
                    if (ea >= 0) check("sel_a", sel_a, ea);
                end
            end
            prev_upd = update_block;
            if (alu_start) begin
                if (q_op_a.size() == 0) unexp("alu_start");
                else begin
                    check("alu_op_a", alu_op_a, q_op_a.pop_front());
                    check("alu_op_b", alu_op_b, q_op_b.pop_front());
                end
            end
            if (core_done) begin
                if (q_err.size() == 0) unexp("core_done");
                else check("core_err", core_err, q_err.pop_front());
            end else if (core_err) begin
                unexp("core_err_alone");
            end
            if (wr_en) begin
                if (q_wr_addr.size() == 0) unexp("wr_en");
                else begin
                    check("wr_addr", wr_addr, q_wr_addr.pop_front());
                    check("wr_data", wr_data, q_wr_data.pop_front());
                end
            end
            if (dbg_valid) begin
                if (q_dbg.size() == 0) unexp("dbg_valid");
                else check("dbg_data", dbg_data, q_dbg.pop_front());
            end
        end
    end

    // ---------------- stimulus
    function automatic logic outs_any();
        return |{core_done, core_err, dbg_valid, dbg_data, sel_a, sel_b, update_block,
                 alu_start, alu_op_a, alu_op_b, wr_en, wr_addr, wr_data};
    endfunction

    task automatic poke(int idx, logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = v; mdl[idx] = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_core(int a, int b, int d, bit we, int dly, bit hang);
        int n;
        n = 0;
        plan_core(a, b, d, we, hang);
        mdl_last_dbg = 1'b0;
        alu_dly = dly; alu_hang = hang;
        @(negedge clk);
        core_sel_a = 5'(a); core_sel_b = 6'(b); core_dst = 6'(d); core_we = we;
        core_req = 1'b1;
        do begin
            @(negedge clk); n++;
            if (n == 1) begin
                core_sel_a = 5'($urandom); core_sel_b = 6'($urandom);
                core_dst = 6'($urandom); core_we = 1'($urandom);
            end
        end while (!core_done && (n < 200));
        if (!core_done) timeout("core_done");
        else check($sformatf("core_lat a=%0d b=%0d d=%0d", a, b, d), n, core_lat(a, b, d, dly, hang));
        core_req = 1'b0;
        $display("core a=%0d b=%0d dst=%0d we=%0d dly=%0d hang=%0d cycles=%0d", a, b, d, we, dly, hang, n);
    endtask

    task automatic run_dbg(int s);
        int n;
        n = 0;
        plan_dbg(s);
        mdl_last_dbg = 1'b1;
        @(negedge clk);
        dbg_sel = 6'(s); dbg_req = 1'b1;
        do begin
            @(negedge clk); n++;
            if (n == 1) dbg_sel = 6'($urandom);
        end while (!dbg_valid && (n < 200));
        if (!dbg_valid) timeout("dbg_valid");
        else check($sformatf("dbg_lat sel=%0d", s), n, ok_b(s) ? 3 : 1);
        dbg_req = 1'b0;
        $display("dbg sel=%0d data=0x%04h cycles=%0d", s, dbg_data, n);
    endtask

    task automatic run_both(int a, int b, int d, bit we, int dly, int s);
        int n, t_core, t_dbg;
        bit dbg_first;
        n = 0; t_core = -1; t_dbg = -1;
        dbg_first = !mdl_last_dbg;
        if (dbg_first) begin plan_dbg(s); plan_core(a, b, d, we, 1'b0); end
        else begin plan_core(a, b, d, we, 1'b0); plan_dbg(s); end
        mdl_last_dbg = !dbg_first;
        alu_dly = dly; alu_hang = 1'b0;
        @(negedge clk);
        core_sel_a = 5'(a); core_sel_b = 6'(b); core_dst = 6'(d); core_we = we;
        dbg_sel = 6'(s);
        core_req = 1'b1; dbg_req = 1'b1;
        do begin
            @(negedge clk); n++;
            if (core_done && (t_core < 0)) begin t_core = n; core_req = 1'b0; end
            if (dbg_valid && (t_dbg < 0)) begin t_dbg = n; dbg_req = 1'b0; end
        end while (((t_core < 0) || (t_dbg < 0)) && (n < 300));
        core_req = 1'b0; dbg_req = 1'b0;
        if ((t_core < 0) || (t_dbg < 0)) timeout("both_done");
        else check("rr_dbg_first", (t_dbg < t_core), dbg_first);
        $display("both core(a=%0d b=%0d dst=%0d) dbg(sel=%0d) core_at=%0d dbg_at=%0d", a, b, d, s, t_core, t_dbg);
    endtask

    function automatic int rnd_b();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return int'($urandom_range(28, 63)) == 34 ? 35 : int'($urandom_range(28, 33));
        if (r < 4) return 34;
        return int'($urandom_range(0, 27));
    endfunction

    function automatic int rnd_a();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(28, 31));
        return int'($urandom_range(0, 27));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kind, total;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs_zero", outs_any(), 0);
        for (int i = 0; i <= 34; i++) begin
            if ((i <= 27) || (i == 34)) poke(i, 16'($urandom));
        end
        poke(3, 16'h1234);
        poke(34, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs_zero", outs_any(), 0);

        // simultaneous requests right after reset: core first, debug sees its write
        run_both(7, 8, 12, 1'b1, 1, 12);
        // r3 + r34 -> r5 with a two-cycle ALU
        run_core(3, 34, 5, 1'b1, 2, 1'b0);
        // bad indices on each core field
        run_core(29, 1, 2, 1'b1, 0, 1'b0);
        run_core(4, 40, 2, 1'b1, 0, 1'b0);
        run_core(4, 5, 30, 1'b1, 0, 1'b0);
        // debug read of the working register, then an invalid debug index
        poke(34, 16'hBEEF);
        run_dbg(34);
        run_dbg(31);
        // after a core-only grant a tie goes to debug
        run_core(1, 2, 3, 1'b1, 0, 1'b0);
        run_both(3, 3, 9, 1'b1, 0, 9);
        run_core(0, 34, 0, 1'b0, 3, 1'b0);

`ifdef ALU_TIMEOUT_EN
        run_core(5, 6, 9, 1'b1, 0, 1'b1);
        alu_hang = 1'b0;
        inject_req = inject_req + 1;
        repeat (6) @(negedge clk);
        $display("late alu_done injected in IDLE");
`endif

        // reset while waiting in EXEC: the transaction disappears
        q_upd_a.push_back(1); q_upd_b.push_back(2);
        q_op_a.push_back(mdl[1]); q_op_b.push_back(mdl[2]);
        alu_hang = 1'b1;
        @(negedge clk);
        core_sel_a = 5'd1; core_sel_b = 6'd2; core_dst = 6'd7; core_we = 1'b1;
        core_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!alu_start && (n < 50));
        if (!alu_start) timeout("alu_start_before_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1; core_req = 1'b0;
        @(negedge clk);
        check("exec_reset_outs_zero", outs_any(), 0);
        reset = 1'b0; alu_hang = 1'b0; mdl_last_dbg = 1'b1;
        repeat (8) @(negedge clk);
        $display("reset during EXEC done");

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) run_core(rnd_a(), rnd_b(), rnd_b(), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
            else if (kind == 1) run_dbg(rnd_b());
            else run_both(int'($urandom_range(0, 27)), int'($urandom_range(0, 27)),
                          int'($urandom_range(0, 27)), 1'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 27)));
        end

        repeat (5) @(negedge clk);
        total = q_upd_b.size() + q_op_a.size() + q_err.size() + q_wr_addr.size() + q_dbg.size();
        check("leftover_expectations", total, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
